// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter_ctrl sequencing controller.
package counter_ctrl_pkg;

    localparam int unsigned WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } ctrl_state_t;

    // A window is in progress while running or paused.
    function automatic logic is_busy(input ctrl_state_t s);
        return (s == ST_RUN) || (s == ST_HOLD);
    endfunction

endpackage

// File: rtl/counter_ctrl_count_core.sv
// Event count register with clr > load0 > inc priority and a terminal-count compare.
module count_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load0_i,
    input  logic             inc_i,
    input  logic [WIDTH-1:0] tc_i,
    output logic [WIDTH-1:0] count_o,
    output logic             term_c_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_inc;

    assign count_inc = count_q + WIDTH'(1);
    assign term_c_o  = (count_inc == tc_i);
    assign count_o   = count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load0_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// Sequencing controller for a gated event-counting window: arm, run, pause,
// terminate, with one-shot or periodic (wrap) completion.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             mode_wrap,
    input  logic [WIDTH-1:0] tc_value,
    input  logic             in,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             err
);

    ctrl_state_t      state_q, state_d;
    logic [WIDTH-1:0] tc_q, tc_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    logic             core_clr_c;
    logic             core_load0_c;
    logic             core_inc_c;
    logic             term_c;

    count_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (core_clr_c),
        .load0_i  (core_load0_c),
        .inc_i    (core_inc_c),
        .tc_i     (tc_q),
        .count_o  (count),
        .term_c_o (term_c)
    );

    // Next-state and flag logic; command priority clear > stop > start > counting.
    always_comb begin
        state_d      = state_q;
        tc_d         = tc_q;
        wrap_d       = wrap_q;
        ovf_d        = ovf_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        core_clr_c   = 1'b0;
        core_load0_c = 1'b0;
        core_inc_c   = 1'b0;

        if (clear) begin
            state_d    = ST_IDLE;
            ovf_d      = 1'b0;
            core_clr_c = 1'b1;
        end else if (stop) begin
            if (state_q == ST_RUN) begin
                state_d = ST_HOLD;
            end
        end else if (start && (state_q == ST_IDLE || state_q == ST_DONE)) begin
            if (tc_value == '0) begin
                err_d = 1'b1;
            end else begin
                tc_d         = tc_value;
                wrap_d       = mode_wrap;
                ovf_d        = 1'b0;
                core_load0_c = 1'b1;
                state_d      = ST_RUN;
            end
        end else if (start && state_q == ST_HOLD) begin
            state_d = ST_RUN;
        end else if (state_q == ST_RUN && in) begin
            if (term_c) begin
                done_d = 1'b1;
                if (wrap_q) begin
                    core_load0_c = 1'b1;
                    ovf_d        = 1'b1;
                end else begin
                    core_inc_c = 1'b1;
                    state_d    = ST_DONE;
                end
            end else begin
                core_inc_c = 1'b1;
            end
        end

        busy_d = is_busy(state_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tc_q    <= '0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tc_q    <= tc_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = ovf_q;
    assign err      = err_q;

endmodule
